multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
Multi-cycle sequencer for the MIPS subset ADD/SUB/AND/OR/SLT, LW, SW, BEQ, J, ADDI/ANDI/ORI/SLTI.
It replaces single-cycle main decode with a Moore FSM that drives a shared ALU/memory datapath over 3-5 cycles per instruction.
Memory accesses use a ready handshake with timeout.
It also provides a retired-instruction counter and error flags.

Parameters:
CNT_WIDTH, 32, width of InstrCount
TIMEOUT, 16, max cycles waited for MemReady in any memory state (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
Opcode  input  6  IR[31:26]; valid from the DECODE state onward
MemReady  input  1  memory completes the current access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU Zero (BEQ)
IorD  output  1  0: memory address = PC; 1: memory address = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
MemtoReg  output  1  register write data: 1 = MDR, 0 = ALUOut
RegDst  output  1  1: rd, 0: rt
RegWrite  output  1  register file write
ALUSrcA  output  1  0: PC, 1: register A
ALUSrcB  output  2  00: register B, 01: constant 4, 10: sign-extended immediate, 11: sign-extended immediate << 2
ALUOp  output  2  same encoding as main decode: 00 add, 01 sub, 10 funct, 11 immediate
PCSource  output  2  00: ALU result, 01: ALUOut, 10: jump target
State  output  4  current state, for debug
IllegalOp  output  1  sticky; set when the FSM enters HALT because of an undefined opcode
BusError  output  1  sticky; set when the FSM enters HALT because of a memory timeout
InstrCount  output  CNT_WIDTH  retired instructions, wraps modulo 2^CNT_WIDTH

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, I_WB=11, HALT=12.
- Control outputs are decoded combinationally from State. Any output not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - Go to DECODE when MemReady=1; otherwise stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Opcode:
  - 0 -> EXEC_R
  - 35 or 43 -> MEM_ADDR
  - 4 -> BRANCH
  - 2 -> JUMP
  - 8, 10, 12, 13 -> EXEC_I
  - any other value -> HALT, and IllegalOp is set.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEM_RD if Opcode=35, else MEM_WR.
- MEM_RD: MemRead=1, IorD=1. Go to MEM_WB when MemReady=1.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
- MEM_WR: MemWrite=1, IorD=1. Go to FETCH when MemReady=1.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: R_WB.
- R_WB: RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next: FETCH.
- JUMP: PCWrite=1, PCSource=10. Next: FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Next: I_WB.
- I_WB: RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
- HALT: all control outputs 0. Stays in HALT until reset.
- Latencies with zero wait states:
  - R-type and immediate: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ and J: 3 cycles
- Timeout:
  - A wait counter clears on entry to FETCH, MEM_RD or MEM_WR and increments each cycle MemReady=0.
  - If the counter reaches TIMEOUT with MemReady=0, the next state is HALT and BusError is set.
  - MemReady=1 in the same cycle as the limit is reached wins: normal transition, no error.
- InstrCount increments on the edge that leaves MEM_WB, MEM_WR (MemReady=1), R_WB, BRANCH, JUMP or I_WB.
- Reset:
  - At the next rising edge with reset=1: State=FETCH; InstrCount, wait counter, IllegalOp and BusError all cleared.
  - While reset=1, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite and RegWrite are forced to 0 combinationally, even mid-instruction.
  - Reset overrides every other transition.
- MemReady is ignored in states that make no memory request.
- Opcode is sampled only in DECODE and MEM_ADDR.

Test Plan:
- reset 1 cycle; then Opcode=0, MemReady=1 held -> State sequence 0,1,6,7,0; RegWrite=1 only in state 7 with RegDst=1; InstrCount=1 after the 4th edge.
- Opcode=35, MemReady low for 3 cycles in MEM_RD -> FSM holds in state 3 for 3 extra cycles; MEM_WB has MemtoReg=1, RegWrite=1; total 8 cycles; no BusError.
- Opcode=43 then 4 then 2, zero wait states -> MemWrite pulses once in state 5; PCWriteCond=1 with PCSource=01 in state 8; PCWrite=1 with PCSource=10 in state 9; InstrCount=3 after 10 cycles.
- Opcode=63 in DECODE -> State=12, IllegalOp=1, all strobes 0; stays there for 20 cycles; reset -> State=0, IllegalOp=0.
- TIMEOUT=16, MemReady held 0 in FETCH -> HALT on the 17th edge, BusError=1, IRWrite never asserted; repeat with MemReady=1 in the limit cycle -> DECODE, BusError=0.
- reset asserted while in MEM_WR with MemReady=1 -> MemWrite=0 that cycle; next State=0, InstrCount unchanged at 0.

Source files
------------

// File: rtl/multi_cycle_ctrl_if.sv
// Control bus between the multi-cycle sequencer and the shared ALU/memory datapath.
// The master side is the sequencer; the slave side is the datapath (or a testbench standing in for it).
interface multi_cycle_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic [5:0]           Opcode;
    logic                 MemReady;
    logic                 PCWrite;
    logic                 PCWriteCond;
    logic                 IorD;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 IRWrite;
    logic                 MemtoReg;
    logic                 RegDst;
    logic                 RegWrite;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ALUOp;
    logic [1:0]           PCSource;
    logic [3:0]           State;
    logic                 IllegalOp;
    logic                 BusError;
    logic [CNT_WIDTH-1:0] InstrCount;

    modport master (
        input  Opcode, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               State, IllegalOp, BusError, InstrCount
    );

    modport slave (
        output Opcode, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               State, IllegalOp, BusError, InstrCount
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Moore-style multi-cycle sequencer for a MIPS subset, with memory-ready timeout,
// sticky error flags and a retired-instruction counter.
module multi_cycle_ctrl #(
    parameter int CNT_WIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                reset,
    multi_cycle_ctrl_if.master  bus
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEM_ADDR = 4'd2;
    localparam logic [3:0] MEM_RD   = 4'd3;
    localparam logic [3:0] MEM_WB   = 4'd4;
    localparam logic [3:0] MEM_WR   = 4'd5;
    localparam logic [3:0] EXEC_R   = 4'd6;
    localparam logic [3:0] R_WB     = 4'd7;
    localparam logic [3:0] BRANCH   = 4'd8;
    localparam logic [3:0] JUMP     = 4'd9;
    localparam logic [3:0] EXEC_I   = 4'd10;
    localparam logic [3:0] I_WB     = 4'd11;
    localparam logic [3:0] HALT     = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [3:0]           state;
    logic [3:0]           state_next;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [CNT_WIDTH-1:0] instr_count;
    logic                 illegal_op;
    logic                 bus_error;

    logic mem_state;
    logic timed_out;
    logic retire;

    assign mem_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    // A ready in the limit cycle still completes the access normally.
    assign timed_out = mem_state && !bus.MemReady && (wait_cnt == WAIT_W'(TIMEOUT));
    assign retire    = (state == MEM_WB) || (state == R_WB) || (state == BRANCH) ||
                       (state == JUMP) || (state == I_WB) ||
                       ((state == MEM_WR) && bus.MemReady);

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            FETCH:    if (bus.MemReady) state_next = DECODE;
                      else if (timed_out) state_next = HALT;
            DECODE: begin
                case (bus.Opcode)
                    OP_RTYPE:                         state_next = EXEC_R;
                    OP_LW, OP_SW:                     state_next = MEM_ADDR;
                    OP_BEQ:                           state_next = BRANCH;
                    OP_J:                             state_next = JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_next = EXEC_I;
                    default:                          state_next = HALT;
                endcase
            end
            MEM_ADDR: state_next = (bus.Opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (bus.MemReady) state_next = MEM_WB;
                      else if (timed_out) state_next = HALT;
            MEM_WB:   state_next = FETCH;
            MEM_WR:   if (bus.MemReady) state_next = FETCH;
                      else if (timed_out) state_next = HALT;
            EXEC_R:   state_next = R_WB;
            R_WB:     state_next = FETCH;
            BRANCH:   state_next = FETCH;
            JUMP:     state_next = FETCH;
            EXEC_I:   state_next = I_WB;
            I_WB:     state_next = FETCH;
            HALT:     state_next = HALT;
            default:  state_next = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state       <= FETCH;
            wait_cnt    <= '0;
            instr_count <= '0;
            illegal_op  <= 1'b0;
            bus_error   <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (mem_state && !bus.MemReady)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if ((state == DECODE) && (state_next == HALT))
                illegal_op <= 1'b1;
            if (timed_out)
                bus_error <= 1'b1;
            if (retire)
                instr_count <= instr_count + CNT_WIDTH'(1);
        end
    end

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       memto_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        memto_reg     = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.MemReady;
                pc_write  = bus.MemReady;
            end
            DECODE:   alu_src_b = 2'b11;
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEM_WB: begin
                memto_reg = 1'b1;
                reg_write = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            I_WB:     reg_write = 1'b1;
            default:  ;
        endcase
        // Side-effecting strobes are suppressed while reset is held, even mid-instruction.
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
        end
    end

    assign bus.PCWrite     = pc_write;
    assign bus.PCWriteCond = pc_write_cond;
    assign bus.IorD        = iord;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.IRWrite     = ir_write;
    assign bus.MemtoReg    = memto_reg;
    assign bus.RegDst      = reg_dst;
    assign bus.RegWrite    = reg_write;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.ALUOp       = alu_op;
    assign bus.PCSource    = pc_source;
    assign bus.State       = state;
    assign bus.IllegalOp   = illegal_op;
    assign bus.BusError    = bus_error;
    assign bus.InstrCount  = instr_count;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: an instruction-path model predicts every output
// each cycle, and literal expectations pin the key sequences.
module tb_multi_cycle_ctrl;
    localparam int CNT_WIDTH = 32;
    localparam int TIMEOUT   = 16;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       memto_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic       rdy = 1'b1;

    int errors = 0;
    int checks = 0;

    multi_cycle_ctrl_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();
    assign bus.Opcode   = op;
    assign bus.MemReady = rdy;

    multi_cycle_ctrl #(.CNT_WIDTH(CNT_WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Control word each state shows, read straight from the state descriptions.
    ctrl_t tab [13];
    initial begin
        for (int i = 0; i < 13; i++) tab[i] = '0;
        tab[0].mem_read = 1'b1;  tab[0].alu_src_b = 2'b01;
        tab[1].alu_src_b = 2'b11;
        tab[2].alu_src_a = 1'b1; tab[2].alu_src_b = 2'b10;
        tab[3].mem_read = 1'b1;  tab[3].iord = 1'b1;
        tab[4].memto_reg = 1'b1; tab[4].reg_write = 1'b1;
        tab[5].mem_write = 1'b1; tab[5].iord = 1'b1;
        tab[6].alu_src_a = 1'b1; tab[6].alu_op = 2'b10;
        tab[7].reg_dst = 1'b1;   tab[7].reg_write = 1'b1;
        tab[8].alu_src_a = 1'b1; tab[8].alu_op = 2'b01; tab[8].pc_write_cond = 1'b1; tab[8].pc_source = 2'b01;
        tab[9].pc_write = 1'b1;  tab[9].pc_source = 2'b10;
        tab[10].alu_src_a = 1'b1; tab[10].alu_src_b = 2'b10; tab[10].alu_op = 2'b11;
        tab[11].reg_write = 1'b1;
    end

    function automatic ctrl_t expect_ctrl(input int st, input logic r, input logic rs);
        ctrl_t c;
        c = tab[st];
        if (st == 0) begin
            c.pc_write = r;
            c.ir_write = r;
        end
        if (rs) begin
            c.pc_write = 0; c.pc_write_cond = 0; c.ir_write = 0;
            c.mem_read = 0; c.mem_write = 0;     c.reg_write = 0;
        end
        return c;
    endfunction

    // Model: each instruction walks a fixed list of states; memory steps may stall.
    int path[$] = '{0, 1};
    int m_state = 0;
    int m_idx = 0;
    int m_wait = 0;
    logic [CNT_WIDTH-1:0] m_cnt = '0;
    bit m_ill = 0;
    bit m_bus = 0;
    bit model_on = 0;

    function automatic void choose_path(input logic [5:0] o);
        case (o)
            6'd0:                    path = '{0, 1, 6, 7};
            6'd35:                   path = '{0, 1, 2, 3, 4};
            6'd43:                   path = '{0, 1, 2, 5};
            6'd4:                    path = '{0, 1, 8};
            6'd2:                    path = '{0, 1, 9};
            6'd8, 6'd10, 6'd12, 6'd13: path = '{0, 1, 10, 11};
            default:                 path = '{0, 1, 12};
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_state = 0; m_idx = 0; m_wait = 0; m_cnt = '0;
            m_ill = 0; m_bus = 0; model_on = 1;
            path = '{0, 1};
        end else if (m_state == 12) begin
            m_state = 12;
        end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !rdy) begin
            if (m_wait == TIMEOUT) begin
                m_state = 12;
                m_bus = 1;
            end else begin
                m_wait++;
            end
        end else begin
            if (m_idx == 1) choose_path(op);
            m_wait = 0;
            if (m_idx == path.size() - 1) begin
                m_idx = 0;
                m_state = 0;
                m_cnt = m_cnt + 1;
            end else begin
                m_idx++;
                m_state = path[m_idx];
                if (m_state == 12) m_ill = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            ctrl_t got;
            got = '{bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                    bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource};
            check("ctrl", 64'(got), 64'(expect_ctrl(m_state, rdy, reset)));
            check("state", 64'(bus.State), 64'(m_state));
            check("flags", {62'd0, bus.IllegalOp, bus.BusError}, {62'd0, m_ill, m_bus});
            check("count", 64'(bus.InstrCount), 64'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int seq[4];
        // Reset state
        rdy = 1'b1;
        op  = 6'd0;
        do_reset();
        check("rst_state", 64'(bus.State), 64'd0);
        check("rst_count", 64'(bus.InstrCount), 64'd0);

        // R-type, zero wait
        seq = '{1, 6, 7, 0};
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rtype_seq", 64'(bus.State), 64'(seq[i]));
            if (i == 1) check("rtype_wb", {62'd0, bus.RegWrite, bus.RegDst}, 64'd0);
        end
        check("rtype_count", 64'(bus.InstrCount), 64'd1);

        // LW with 3 wait cycles in MEM_RD
        op = 6'd35;
        for (int i = 0; i < 3; i++) tick();
        check("lw_memrd", 64'(bus.State), 64'd3);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lw_hold", 64'(bus.State), 64'd3);
        end
        rdy = 1'b1;
        tick();
        check("lw_wb", {60'd0, bus.State}, 64'd4);
        check("lw_wb_ctrl", {62'd0, bus.MemtoReg, bus.RegWrite}, 64'd3);
        tick();
        check("lw_done", 64'(bus.State), 64'd0);
        check("lw_count", 64'(bus.InstrCount), 64'd2);
        check("lw_buserr", 64'(bus.BusError), 64'd0);

        // SW, BEQ, J back to back
        op = 6'd43;
        for (int i = 0; i < 3; i++) tick();
        check("sw_memwr", 64'(bus.MemWrite), 64'd1);
        tick();
        op = 6'd4;
        for (int i = 0; i < 2; i++) tick();
        check("beq_ctrl", {61'd0, bus.PCWriteCond, bus.PCSource}, 64'd5);
        tick();
        op = 6'd2;
        for (int i = 0; i < 2; i++) tick();
        check("j_ctrl", {61'd0, bus.PCWrite, bus.PCSource}, 64'd6);
        tick();
        check("sbj_count", 64'(bus.InstrCount), 64'd5);

        // Immediate ops
        op = 6'd13;
        for (int i = 0; i < 4; i++) tick();
        op = 6'd10;
        for (int i = 0; i < 4; i++) tick();
        check("imm_count", 64'(bus.InstrCount), 64'd7);

        // Illegal opcode halts and stays
        op = 6'd63;
        for (int i = 0; i < 2; i++) tick();
        check("ill_state", 64'(bus.State), 64'd12);
        check("ill_flag", 64'(bus.IllegalOp), 64'd1);
        for (int i = 0; i < 20; i++) tick();
        check("ill_stay", 64'(bus.State), 64'd12);
        op = 6'd0;
        do_reset();
        check("ill_clr", {60'd0, bus.State, bus.IllegalOp}, 64'd0);

        // FETCH timeout: HALT on the 17th edge
        rdy = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) tick();
        check("to_wait", 64'(bus.State), 64'd0);
        tick();
        check("to_halt", 64'(bus.State), 64'd12);
        check("to_flag", 64'(bus.BusError), 64'd1);
        do_reset();
        for (int i = 0; i < TIMEOUT; i++) tick();
        rdy = 1'b1;
        tick();
        check("to_rescue", 64'(bus.State), 64'd1);
        check("to_noerr", 64'(bus.BusError), 64'd0);
        for (int i = 0; i < 3; i++) tick();

        // Reset in MEM_WR with ready high
        do_reset();
        op = 6'd43;
        for (int i = 0; i < 3; i++) tick();
        check("rst_wr_state", 64'(bus.State), 64'd5);
        reset = 1'b1;
        #1;
        check("rst_wr_gate", 64'(bus.MemWrite), 64'd0);
        tick();
        reset = 1'b0;
        check("rst_wr_next", 64'(bus.State), 64'd0);
        check("rst_wr_cnt", 64'(bus.InstrCount), 64'd0);
        tick();

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
